// File: rtl/arrow_scheduler.sv
// arrow_scheduler: spawns, retires and scores the pool of arrow instances.
// Ports: clk/rst, hcount/vcount (frame tick), start, per-slot done/hit in; slot valid/dir, speed, lives, score, state out.
module arrow_scheduler #(
  parameter int          NUM_SLOTS        = 4,
  parameter int          SPAWN_INTERVAL   = 60,
  parameter int          START_LIVES      = 3,
  parameter int          BLOCKS_PER_LEVEL = 8,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   start_in,
  input  logic [NUM_SLOTS-1:0]   slot_done_in,
  input  logic [NUM_SLOTS-1:0]   hit_player_in,
  output logic [NUM_SLOTS-1:0]   slot_valid_out,
  output logic [2*NUM_SLOTS-1:0] slot_direction_out,
  output logic [2:0]             speed_out,
  output logic [1:0]             lives_out,
  output logic [15:0]            score_out,
  output logic                   game_over_out,
  output logic [1:0]             state_out
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10
  } state_e;

  localparam int              CW       = $clog2(SPAWN_INTERVAL);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SPAWN_INTERVAL - 1);
  localparam logic [16:0]     BPL      = 17'(BLOCKS_PER_LEVEL);
  localparam logic [1:0]      LIVES0   = 2'(START_LIVES);

  state_e                 state_q, state_d;
  logic [NUM_SLOTS-1:0]   valid_q, valid_d;
  logic [2*NUM_SLOTS-1:0] dir_q, dir_d;
  logic [2:0]             speed_q, speed_d;
  logic [1:0]             lives_q, lives_d;
  logic [15:0]            score_q, score_d;
  logic [15:0]            lvl_q, lvl_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic                   over_q;

  logic                   frame_tick;
  logic [NUM_SLOTS-1:0]   retire, blk, hit;
  logic [3:0]             nblk, nhit;
  logic                   lose;
  logic [NUM_SLOTS-1:0]   spawn_oh;
  logic                   any_free;
  logic                   fb;
  logic [16:0]            score_sum, lvl_sum, steps, spd_sum;

  assign frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign retire     = valid_q & slot_done_in;
  assign blk        = retire & ~hit_player_in;
  assign hit        = retire & hit_player_in;
  assign fb         = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    nblk = '0;
    nhit = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      nblk = nblk + 4'(blk[i]);
      nhit = nhit + 4'(hit[i]);
    end
  end

  // Lowest-index free slot as a one-hot mask.
  always_comb begin
    spawn_oh = '0;
    any_free = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!any_free && !valid_q[i]) begin
        spawn_oh[i] = 1'b1;
        any_free    = 1'b1;
      end
    end
  end

  assign lose = (nhit != 4'd0) && (nhit >= {2'b00, lives_q});

  // Speed follows the per-game block count in whole levels.
  assign score_sum = {1'b0, score_q} + 17'(nblk);
  assign lvl_sum   = {1'b0, lvl_q} + 17'(nblk);
  assign steps     = lvl_sum / BPL;
  assign spd_sum   = 17'(speed_q) + steps;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_in) state_d = RUN;
      RUN:     if (lose) state_d = OVER;
      OVER:    if (start_in) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    dir_d   = dir_q;
    speed_d = speed_q;
    lives_d = lives_q;
    score_d = score_q;
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    lfsr_d  = lfsr_q;
    unique case (state_q)
      RUN: begin
        valid_d = valid_q & ~retire;
        score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        lvl_d   = 16'(lvl_sum % BPL);
        speed_d = (spd_sum > 17'd7) ? 3'd7 : spd_sum[2:0];
        lives_d = lose ? 2'd0 : lives_q - nhit[1:0];
        if (frame_tick) begin
          lfsr_d = {lfsr_q[14:0], fb};
          // Interval counter stalls while a spawn is waiting.
          if (pend_q) begin
            if (any_free) begin
              valid_d = valid_d | spawn_oh;
              for (int i = 0; i < NUM_SLOTS; i++) begin
                if (spawn_oh[i]) dir_d[2*i +: 2] = lfsr_q[1:0];
              end
              pend_d = 1'b0;
            end
          end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            pend_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        if (lose) valid_d = '0;
      end
      default: begin
        valid_d = '0;
        if (start_in) begin
          speed_d = 3'd1;
          lives_d = LIVES0;
          score_d = '0;
          lvl_d   = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
          lfsr_d  = LFSR_SEED;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dir_q   <= '0;
      speed_q <= 3'd1;
      lives_q <= LIVES0;
      score_q <= '0;
      lvl_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      over_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dir_q   <= dir_d;
      speed_q <= speed_d;
      lives_q <= lives_d;
      score_q <= score_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      lfsr_q  <= lfsr_d;
      over_q  <= (state_d == OVER);
    end
  end

  assign slot_valid_out     = valid_q;
  assign slot_direction_out = dir_q;
  assign speed_out          = speed_q;
  assign lives_out          = lives_q;
  assign score_out          = score_q;
  assign game_over_out      = over_q;
  assign state_out          = state_q;

endmodule

// File: tb/tb_arrow_scheduler.sv
// tb_arrow_scheduler: directed + random stimulus against a behavioural model.
// Drives frame ticks through hcount/vcount and checks every output each cycle.
module tb_arrow_scheduler;

  localparam int NS  = 4;
  localparam int SI  = 4;
  localparam int SL  = 3;
  localparam int BPL = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [10:0]   hcount_in;
  logic [9:0]    vcount_in;
  logic          start_in;
  logic [NS-1:0] slot_done_in;
  logic [NS-1:0] hit_player_in;
  logic [NS-1:0] slot_valid_out;
  logic [2*NS-1:0] slot_direction_out;
  logic [2:0]    speed_out;
  logic [1:0]    lives_out;
  logic [15:0]   score_out;
  logic          game_over_out;
  logic [1:0]    state_out;

  always #5 clk = ~clk;

  arrow_scheduler #(
    .NUM_SLOTS(NS),
    .SPAWN_INTERVAL(SI),
    .START_LIVES(SL),
    .BLOCKS_PER_LEVEL(BPL),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hcount_in(hcount_in),
    .vcount_in(vcount_in),
    .start_in(start_in),
    .slot_done_in(slot_done_in),
    .hit_player_in(hit_player_in),
    .slot_valid_out(slot_valid_out),
    .slot_direction_out(slot_direction_out),
    .speed_out(speed_out),
    .lives_out(lives_out),
    .score_out(score_out),
    .game_over_out(game_over_out),
    .state_out(state_out)
  );

  int checks = 0;
  int errors = 0;

  int          m_state;
  bit [NS-1:0] m_valid;
  int          m_dir [NS];
  int          m_blocks;
  int          m_lives;
  int          m_frames;
  bit          m_pend;
  int          m_lfsr;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int lfsr_adv(int l);
    int b;
    b = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | b) & 16'hFFFF;
  endfunction

  function automatic int m_score();
    return (m_blocks > 65535) ? 65535 : m_blocks;
  endfunction

  function automatic int m_speed();
    int s;
    s = 1 + m_blocks / BPL;
    return (s > 7) ? 7 : s;
  endfunction

  task automatic model_init();
    m_valid  = '0;
    m_blocks = 0;
    m_lives  = SL;
    m_frames = 0;
    m_pend   = 1'b0;
    m_lfsr   = 16'hACE1;
  endtask

  task automatic model_reset();
    model_init();
    m_state = 0;
    for (int i = 0; i < NS; i++) m_dir[i] = 0;
  endtask

  task automatic model_step(bit r, bit tick, bit st,
                            bit [NS-1:0] d, bit [NS-1:0] h);
    bit [NS-1:0] old;
    int nb, nh, f;
    if (r) begin
      model_reset();
      return;
    end
    if (m_state != 1) begin
      m_valid = '0;
      if (st) begin
        model_init();
        m_state = 1;
      end
      return;
    end
    old = m_valid;
    nb = 0;
    nh = 0;
    for (int i = 0; i < NS; i++) begin
      if (old[i] && d[i]) begin
        m_valid[i] = 1'b0;
        if (h[i]) nh++;
        else nb++;
      end
    end
    m_blocks += nb;
    m_lives = (nh >= m_lives) ? 0 : m_lives - nh;
    if (nh > 0 && m_lives == 0) begin
      m_state = 2;
      m_valid = '0;
      return;
    end
    if (tick) begin
      if (m_pend) begin
        f = -1;
        for (int i = 0; i < NS; i++) if (f < 0 && !old[i]) f = i;
        if (f >= 0) begin
          m_valid[f] = 1'b1;
          m_dir[f]   = m_lfsr & 3;
          m_pend     = 1'b0;
        end
      end else begin
        m_frames++;
        if (m_frames == SI) begin
          m_frames = 0;
          m_pend   = 1'b1;
        end
      end
      m_lfsr = lfsr_adv(m_lfsr);
    end
  endtask

  task automatic compare_all();
    chk("state", state_out, m_state);
    chk("valid", slot_valid_out, m_valid);
    chk("lives", lives_out, m_lives);
    chk("score", score_out, m_score());
    chk("speed", speed_out, m_speed());
    chk("over", game_over_out, (m_state == 2) ? 1 : 0);
    for (int i = 0; i < NS; i++)
      if (m_valid[i]) chk("dir", slot_direction_out[2*i +: 2], m_dir[i]);
  endtask

  task automatic cyc(bit r, bit tick, bit st, bit [NS-1:0] d, bit [NS-1:0] h);
    rst           = r;
    start_in      = st;
    slot_done_in  = d;
    hit_player_in = h;
    if (tick) begin
      hcount_in = 11'd0;
      vcount_in = 10'd0;
    end else begin
      hcount_in = 11'($urandom_range(1, 799));
      vcount_in = 10'($urandom_range(0, 524));
    end
    model_step(r, tick, st, d, h);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic frames(int n);
    for (int f = 0; f < n; f++)
      for (int c = 0; c < 4; c++) cyc(1'b0, c == 0, 1'b0, '0, '0);
  endtask

  int exp_dir [NS];
  int l;
  int ph;
  bit [NS-1:0] d, h;

  initial begin
    model_reset();
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    chk("rst_state", state_out, 0);
    chk("rst_dir", slot_direction_out, 0);
    chk("rst_lives", lives_out, 3);
    chk("rst_speed", speed_out, 1);

    frames(3);
    chk("idle_state", state_out, 0);
    chk("idle_valid", slot_valid_out, 0);

    cyc(1'b0, 1'b0, 1'b1, '0, '0);
    chk("run", state_out, 1);

    // Slots fill on ticks 5,10,15,20; a further spawn stalls.
    l = 16'hACE1;
    for (int t = 1; t <= 20; t++) begin
      if (t % 5 == 0) exp_dir[t/5 - 1] = l & 3;
      l = lfsr_adv(l);
    end
    frames(26);
    chk("full", slot_valid_out, 4'hF);
    for (int i = 0; i < NS; i++)
      chk("seq_dir", slot_direction_out[2*i +: 2], exp_dir[i]);

    cyc(1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000);
    chk("s2_drop", slot_valid_out, 4'b1011);
    chk("score1", score_out, 1);
    frames(1);
    chk("refill", slot_valid_out, 4'hF);

    cyc(1'b0, 1'b0, 1'b0, 4'b1011, 4'b0011);
    chk("mix_score", score_out, 2);
    chk("mix_lives", lives_out, 1);
    chk("mix_valid", slot_valid_out, 4'b0100);

    cyc(1'b0, 1'b0, 1'b0, 4'b0100, 4'b0100);
    chk("over_state", state_out, 2);
    chk("over_flag", game_over_out, 1);
    chk("over_valid", slot_valid_out, 0);
    for (int k = 0; k < 3; k++) cyc(1'b0, k == 0, 1'b0, 4'hF, 4'hF);
    chk("over_score", score_out, 2);
    chk("over_lives", lives_out, 0);

    cyc(1'b0, 1'b0, 1'b1, '0, '0);
    chk("restart_lives", lives_out, 3);
    chk("restart_score", score_out, 0);

    // Block every arrow as soon as it appears.
    for (int k = 0; k < 3000 && m_blocks < 8; k++)
      cyc(1'b0, (k % 4) == 0, 1'b0, m_valid, '0);
    chk("speed2", speed_out, 2);
    for (int k = 0; k < 6000 && m_blocks < 60; k++)
      cyc(1'b0, (k % 4) == 0, 1'b0, m_valid, '0);
    chk("speed_sat", speed_out, 7);

    ph = 0;
    for (int k = 0; k < 2500; k++) begin
      d = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      h = ($urandom_range(0, 31) == 0) ? NS'($urandom) : '0;
      cyc(1'b0, ph == 0, $urandom_range(0, 63) == 0, d, h);
      ph = (ph == 0) ? $urandom_range(1, 4) : ph - 1;
    end

    cyc(1'b0, 1'b0, 1'b1, '0, '0);
    frames(12);
    cyc(1'b1, 1'b0, 1'b0, '0, '0);
    chk("mrst_state", state_out, 0);
    chk("mrst_valid", slot_valid_out, 0);
    chk("mrst_dir", slot_direction_out, 0);
    chk("mrst_speed", speed_out, 1);
    chk("mrst_score", score_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
